inst_fetch: RTL and testbench

- Front-end fetch stage of the 6502 core, directly upstream of prime_decoder.
- Reads the opcode byte at the program counter from a single-port byte memory.
- Obtains the instruction length (1-3 bytes) from the decoder's length lookup, fetches the operand bytes, and presents the assembled instruction with its PC to decode over a valid/ready handshake.
- Owns the architectural fetch PC; execute (branch/jump) redirects it.

---
 rtl/inst_fetch_if.sv | 30 +++
 rtl/inst_fetch.sv | 100 ++++++++++
 tb/tb_inst_fetch.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: byte-memory read port, decoder length lookup,
// execute redirect and the instruction valid/ready handoff to decode.
interface inst_fetch_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic [7:0]  peek_op;
  logic [1:0]  len_in;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  inst_op;
  logic [7:0]  inst_lo;
  logic [7:0]  inst_hi;
  logic [1:0]  inst_len;
  logic [15:0] inst_pc;

  modport master (
    output mem_addr, mem_rd, peek_op, inst_valid,
           inst_op, inst_lo, inst_hi, inst_len, inst_pc,
    input  mem_rdata, len_in, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_addr, mem_rd, peek_op, inst_valid,
           inst_op, inst_lo, inst_hi, inst_len, inst_pc,
    output mem_rdata, len_in, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// 6502 fetch stage: reads opcode plus 0-2 operand bytes at the fetch PC and
// hands the assembled instruction to decode; execute may redirect the PC.
module inst_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  typedef enum logic [2:0] {FETCH, CAP_OP, CAP_LO, CAP_HI, HOLD} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_pc;
  logic [15:0] r_inst_pc;
  logic [7:0]  r_op;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic [1:0]  r_len;
  logic [1:0]  w_len;
  logic        w_rd;

  // Length 0 from the lookup means a single-byte instruction.
  assign w_len        = (bus.len_in == 2'd0) ? 2'd1 : bus.len_in;
  assign bus.peek_op  = (r_state == CAP_OP) ? bus.mem_rdata : r_op;
  assign bus.mem_rd   = w_rd & ~rst;

  assign bus.inst_op  = r_op;
  assign bus.inst_lo  = r_lo;
  assign bus.inst_hi  = r_hi;
  assign bus.inst_len = r_len;
  assign bus.inst_pc  = r_inst_pc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   w_next = CAP_OP;
      CAP_OP:  w_next = (w_len == 2'd1) ? HOLD : CAP_LO;
      CAP_LO:  w_next = (r_len == 2'd3) ? CAP_HI : HOLD;
      CAP_HI:  w_next = HOLD;
      HOLD:    w_next = bus.inst_ready ? FETCH : HOLD;
      default: w_next = FETCH;
    endcase
    if (bus.redirect) w_next = FETCH;
  end

  always_comb begin
    w_rd           = 1'b0;
    bus.mem_addr   = r_pc;
    bus.inst_valid = (r_state == HOLD);
    case (r_state)
      FETCH: w_rd = 1'b1;
      CAP_OP: begin
        w_rd         = (w_len != 2'd1);
        bus.mem_addr = r_pc + 16'd1;
      end
      CAP_LO: begin
        w_rd         = (r_len == 2'd3);
        bus.mem_addr = r_pc + 16'd2;
      end
      default: w_rd = 1'b0;
    endcase
  end

  // A redirect wins over the PC advance even when the transfer completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_inst_pc <= 16'h0000;
      r_op      <= 8'h00;
      r_lo      <= 8'h00;
      r_hi      <= 8'h00;
      r_len     <= 2'd0;
    end else begin
      case (r_state)
        CAP_OP: begin
          r_op      <= bus.mem_rdata;
          r_len     <= w_len;
          r_lo      <= 8'h00;
          r_hi      <= 8'h00;
          r_inst_pc <= r_pc;
        end
        CAP_LO:  r_lo <= bus.mem_rdata;
        CAP_HI:  r_hi <= bus.mem_rdata;
        default: ;
      endcase
      if (bus.redirect)
        r_pc <= bus.redirect_pc;
      else if (r_state == HOLD && bus.inst_ready)
        r_pc <= r_pc + {14'd0, r_len};
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: byte memory with one-cycle read latency,
// opcode length table, cycle-by-cycle checks against hand-computed values.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] mem [0:65535];
  int assertCount = 0;
  int failCount   = 0;
  int xferCount   = 0;
  int xferBase;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(16'h0200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] lenOf(input logic [7:0] op);
    case (op)
      8'hEA:   lenOf = 2'd1;
      8'h00:   lenOf = 2'd0;
      8'hA9:   lenOf = 2'd2;
      8'hAD:   lenOf = 2'd3;
      default: lenOf = 2'd1;
    endcase
  endfunction

  assign bus.len_in = lenOf(bus.peek_op);

  // Read data appears one cycle after the strobe; idle cycles return a marker.
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : 8'h5A;
    if (bus.inst_valid && bus.inst_ready) xferCount <= xferCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkInst(input string tag, input logic [7:0] op, input logic [7:0] lo,
                           input logic [7:0] hi, input logic [1:0] len, input logic [15:0] pc);
    checkOutput({tag, ".valid"}, bus.inst_valid, 1);
    checkOutput({tag, ".op"},    bus.inst_op, op);
    checkOutput({tag, ".lo"},    bus.inst_lo, lo);
    checkOutput({tag, ".hi"},    bus.inst_hi, hi);
    checkOutput({tag, ".len"},   bus.inst_len, len);
    checkOutput({tag, ".pc"},    bus.inst_pc, pc);
    checkOutput({tag, ".rd"},    bus.mem_rd, 0);
  endtask

  task automatic checkRead(input string tag, input logic [15:0] addr);
    checkOutput({tag, ".rd"},   bus.mem_rd, 1);
    checkOutput({tag, ".addr"}, bus.mem_addr, addr);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".valid"}, bus.inst_valid, 0);
    checkOutput({tag, ".rd"},    bus.mem_rd, 0);
    checkOutput({tag, ".op"},    bus.inst_op, 0);
    checkOutput({tag, ".lo"},    bus.inst_lo, 0);
    checkOutput({tag, ".hi"},    bus.inst_hi, 0);
    checkOutput({tag, ".len"},   bus.inst_len, 0);
    checkOutput({tag, ".pc"},    bus.inst_pc, 0);
  endtask

  task automatic applyStimulus(input logic r, input logic redir,
                               input logic [15:0] rpc, input logic ready);
    rst             = r;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.inst_ready  = ready;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
    mem[16'h0200] = 8'hEA;
    mem[16'h0201] = 8'h00;
    mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'h0300] = 8'hA9; mem[16'h0301] = 8'h55;
    mem[16'h0302] = 8'hAD; mem[16'h0303] = 8'h77; mem[16'h0304] = 8'h88;
    mem[16'h0400] = 8'hEA;
    mem[16'h0500] = 8'hEA;

    // Reset state, then one-byte NOP at RESET_PC
    applyStimulus(1, 0, 16'h0000, 1);
    tick(); tick();
    checkReset("reset");
    applyStimulus(0, 0, 16'h0000, 1);
    checkRead("t1.fetch", 16'h0200);
    tick();
    checkOutput("t1.capop.peek", bus.peek_op, 8'hEA);
    checkOutput("t1.capop.rd", bus.mem_rd, 0);
    checkOutput("t1.capop.valid", bus.inst_valid, 0);
    tick();
    checkInst("t1.hold", 8'hEA, 8'h00, 8'h00, 2'd1, 16'h0200);
    tick();
    checkOutput("t1.next.valid", bus.inst_valid, 0);
    checkRead("t1.next", 16'h0201);
    // Opcode with lookup length 0 behaves as one byte
    tick(); tick();
    checkInst("len0.hold", 8'h00, 8'h00, 8'h00, 2'd1, 16'h0201);
    applyStimulus(0, 1, 16'hFFFE, 0);
    tick();
    applyStimulus(0, 0, 16'h0000, 0);

    // Three-byte instruction wrapping through 0000
    checkOutput("t2.fetch.valid", bus.inst_valid, 0);
    checkRead("t2.fetch", 16'hFFFE);
    tick(); checkRead("t2.capop", 16'hFFFF);
    tick(); checkRead("t2.caplo", 16'h0000);
    tick(); checkOutput("t2.caphi.rd", bus.mem_rd, 0);
    checkOutput("t2.caphi.valid", bus.inst_valid, 0);
    tick();
    checkInst("t2.hold", 8'hAD, 8'h34, 8'h12, 2'd3, 16'hFFFE);
    applyStimulus(0, 0, 16'h0000, 1);
    tick(); checkRead("t2.next", 16'h0001);
    applyStimulus(0, 1, 16'h0300, 0);
    tick();
    applyStimulus(0, 0, 16'h0000, 0);

    // Backpressure on a two-byte instruction
    checkRead("t3.fetch", 16'h0300);
    tick(); checkRead("t3.capop", 16'h0301);
    tick(); checkOutput("t3.caplo.rd", bus.mem_rd, 0);
    tick();
    checkInst("t3.hold", 8'hA9, 8'h55, 8'h00, 2'd2, 16'h0300);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkInst("t3.stall", 8'hA9, 8'h55, 8'h00, 2'd2, 16'h0300);
    end
    applyStimulus(0, 0, 16'h0000, 1);
    tick();
    checkOutput("t3.next.valid", bus.inst_valid, 0);
    checkRead("t3.next", 16'h0302);

    // Redirect while capturing the first operand
    tick(); checkRead("t4.capop", 16'h0303);
    tick(); checkRead("t4.caplo", 16'h0304);
    applyStimulus(0, 1, 16'h0400, 1);
    tick();
    applyStimulus(0, 0, 16'h0000, 1);
    checkOutput("t4.redir.valid", bus.inst_valid, 0);
    checkRead("t4.redir", 16'h0400);
    tick();
    checkOutput("t4.capop.valid", bus.inst_valid, 0);
    checkOutput("t4.capop.peek", bus.peek_op, 8'hEA);
    tick();
    checkInst("t4.hold", 8'hEA, 8'h00, 8'h00, 2'd1, 16'h0400);
    applyStimulus(0, 1, 16'h0300, 0);
    tick();
    applyStimulus(0, 0, 16'h0000, 0);

    // Redirect coincident with acceptance
    tick(); tick(); tick();
    checkInst("t5.hold", 8'hA9, 8'h55, 8'h00, 2'd2, 16'h0300);
    xferBase = xferCount;
    applyStimulus(0, 1, 16'h0500, 1);
    tick();
    applyStimulus(0, 0, 16'h0000, 0);
    checkOutput("t5.redir.valid", bus.inst_valid, 0);
    checkRead("t5.redir", 16'h0500);
    tick(); tick();
    checkInst("t5.hold2", 8'hEA, 8'h00, 8'h00, 2'd1, 16'h0500);
    checkOutput("t5.xfers", xferCount - xferBase, 1);

    // Reset asserted while capturing the high operand byte
    applyStimulus(0, 1, 16'hFFFE, 1);
    tick();
    applyStimulus(0, 0, 16'h0000, 1);
    tick(); tick(); tick();
    checkOutput("t6.caphi.rd", bus.mem_rd, 0);
    applyStimulus(1, 0, 16'h0000, 1);
    tick();
    checkReset("t6.reset");
    applyStimulus(0, 0, 16'h0000, 1);
    checkRead("t6.fetch", 16'h0200);
    tick();
    checkOutput("t6.capop.peek", bus.peek_op, 8'hEA);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
